fp_compare_unit: RTL and testbench

Pipelined, parametrised IEEE-754 floating-point compare and min/max unit for the FPU execute path. Operations are FEQ, FLT, FLE, FMIN and FMAX with RISC-V F-extension semantics: exact comparison (no tolerance band), NaN-aware, signed-zero aware, with an invalid-operation flag. It accepts one operation per cycle through a valid/ready handshake and returns results after a fixed two-stage pipeline with full backpressure.

---
 rtl/fp_compare_unit_if.sv | 28 ++
 rtl/fp_compare_unit.sv | 176 +++++++++++++++++
 tb/tb_fp_compare_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_compare_unit_if.sv
// Request/response bundle for the FP compare unit: valid/ready on both sides,
// operands and tag in, result, tag and invalid flag out.
interface fp_compare_unit_if #(
  parameter int FLEN = 32,
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [FLEN-1:0] in_a;
  logic [FLEN-1:0] in_b;
  logic [4:0]      in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_tag;
  logic            out_nv;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_nv
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_nv
  );
endinterface

// File: rtl/fp_compare_unit.sv
// Two-stage IEEE-754 FEQ/FLT/FLE/FMIN/FMAX unit with RISC-V F semantics.
// S1 registers operands and their classification; S2 forms the result in the output registers.
module fp_compare_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = 32
) (
  input logic              clk,
  input logic              rst_n,
  fp_compare_unit_if.slave bus
);
  localparam int FLEN = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;

  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
  } fp_class_t;

  function automatic fp_class_t classify(input logic [FLEN-1:0] x);
    fp_class_t c;
    logic      exp_ones;
    logic      exp_zero;
    logic      frac_zero;
    exp_ones  = &x[FLEN-2:MAN_W];
    exp_zero  = ~|x[FLEN-2:MAN_W];
    frac_zero = ~|x[MAN_W-1:0];
    c.nan     = exp_ones & ~frac_zero;
    c.snan    = exp_ones & ~frac_zero & ~x[MAN_W-1];
    c.zero    = exp_zero & frac_zero;
    return c;
  endfunction

  logic            s1_valid;
  logic [2:0]      s1_op;
  logic [4:0]      s1_tag;
  logic [FLEN-1:0] s1_a;
  logic [FLEN-1:0] s1_b;
  fp_class_t       s1_a_cls;
  fp_class_t       s1_b_cls;

  logic            s2_valid;
  logic [XLEN-1:0] s2_data;
  logic [4:0]      s2_tag;
  logic            s2_nv;

  logic            s2_load;
  logic            s1_load;

  logic            sign_a;
  logic            sign_b;
  logic            mag_lt;
  logic            mag_gt;
  logic            both_zero;
  logic            any_nan;
  logic            any_snan;
  logic            a_below_b;
  logic            lt_ord;
  logic            eq_ord;
  logic [FLEN-1:0] canon_nan;
  logic [FLEN-1:0] minmax;
  logic [XLEN-1:0] res_data;
  logic            res_nv;

  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid
  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  assign canon_nan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  always_comb begin
    sign_a    = s1_a[FLEN-1];
    sign_b    = s1_b[FLEN-1];
    mag_lt    = s1_a[FLEN-2:0] < s1_b[FLEN-2:0];
    mag_gt    = s1_a[FLEN-2:0] > s1_b[FLEN-2:0];
    both_zero = s1_a_cls.zero && s1_b_cls.zero;
    any_nan   = s1_a_cls.nan || s1_b_cls.nan;
    any_snan  = s1_a_cls.snan || s1_b_cls.snan;

    // Total order with -0 strictly below +0; compares then fold the zeros together.
    if (sign_a != sign_b) begin
      a_below_b = sign_a;
    end else if (sign_a) begin
      a_below_b = mag_gt;
    end else begin
      a_below_b = mag_lt;
    end
    lt_ord = a_below_b && !both_zero;
    eq_ord = (s1_a == s1_b) || both_zero;

    if (s1_a_cls.nan && s1_b_cls.nan) begin
      minmax = canon_nan;
    end else if (s1_a_cls.nan) begin
      minmax = s1_b;
    end else if (s1_b_cls.nan) begin
      minmax = s1_a;
    end else if (s1_op == OP_FMAX) begin
      minmax = a_below_b ? s1_b : s1_a;
    end else begin
      minmax = a_below_b ? s1_a : s1_b;
    end

    res_data = '0;
    res_nv   = 1'b0;
    case (s1_op)
      OP_FEQ: begin
        res_data = XLEN'(eq_ord && !any_nan);
        res_nv   = any_snan;
      end
      OP_FLT: begin
        res_data = XLEN'(lt_ord && !any_nan);
        res_nv   = any_nan;
      end
      OP_FLE: begin
        res_data = XLEN'((lt_ord || eq_ord) && !any_nan);
        res_nv   = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        res_data = XLEN'(minmax);
        res_nv   = any_snan;
      end
      default: begin
        res_data = '0;
        res_nv   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_a_cls <= '0;
      s1_b_cls <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_nv    <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= res_data;
          s2_tag  <= s1_tag;
          s2_nv   <= res_nv;
        end
      end
      if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op    <= bus.in_op;
          s1_tag   <= bus.in_tag;
          s1_a     <= bus.in_a;
          s1_b     <= bus.in_b;
          s1_a_cls <= classify(bus.in_a);
          s1_b_cls <= classify(bus.in_b);
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_tag   = s2_tag;
  assign bus.out_nv    = s2_nv;
endmodule

// File: tb/tb_fp_compare_unit.sv
// Directed bench for fp_compare_unit: single and double precision instances,
// expected results queued on acceptance and compared as results leave.
module tb_fp_compare_unit;
  localparam logic [2:0] FEQ  = 3'd0;
  localparam logic [2:0] FLT  = 3'd1;
  localparam logic [2:0] FLE  = 3'd2;
  localparam logic [2:0] FMIN = 3'd3;
  localparam logic [2:0] FMAX = 3'd4;
  localparam logic [2:0] RSV  = 3'd5;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        nv;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        nv;
  } vec_t;

  vec_t vecs [21] = '{
    '{FEQ,  32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0},
    '{FEQ,  32'h3F800000, 32'h3F800001, 32'h00000000, 1'b0},
    '{FLT,  32'hBF800000, 32'h3F800000, 32'h00000001, 1'b0},
    '{FLE,  32'h40000000, 32'h3F800000, 32'h00000000, 1'b0},
    '{FEQ,  32'h00000000, 32'h80000000, 32'h00000001, 1'b0},
    '{FLT,  32'h80000000, 32'h00000000, 32'h00000000, 1'b0},
    '{FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0},
    '{FMAX, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0},
    '{FEQ,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0},
    '{FEQ,  32'h7FA00000, 32'h3F800000, 32'h00000000, 1'b1},
    '{FLT,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1},
    '{FMIN, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0},
    '{FMAX, 32'h7FA00000, 32'h7FC00000, 32'h7FC00000, 1'b1},
    '{RSV,  32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0},
    '{FLE,  32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0},
    '{FLT,  32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0},
    '{FLE,  32'h00000001, 32'h00000000, 32'h00000000, 1'b0},
    '{FMIN, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0},
    '{FMAX, 32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0},
    '{FLE,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0},
    '{FMAX, 32'h3F800000, 32'h7F800001, 32'h3F800000, 1'b1}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done32 = 0;
  exp_t q32 [$];
  exp_t q64 [$];

  always #5 clk = ~clk;

  fp_compare_unit_if #(.FLEN(32), .XLEN(32)) bus ();
  fp_compare_unit_if #(.FLEN(64), .XLEN(64)) bus64 ();

  fp_compare_unit #(.EXP_W(8), .MAN_W(23), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fp_compare_unit #(.EXP_W(11), .MAN_W(52), .XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Output-side scoreboards: every cycle a result is presented it must equal the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      check("extra_result32", {63'b0, bus.out_valid}, {63'b0, q32.size() > 0});
      if (q32.size() > 0) begin
        e = q32[0];
        check("data32", {32'b0, bus.out_data}, {32'b0, e.data[31:0]});
        check("tag32", {59'b0, bus.out_tag}, {59'b0, e.tag});
        check("nv32", {63'b0, bus.out_nv}, {63'b0, e.nv});
        if (bus.out_ready) begin
          void'(q32.pop_front());
          done32++;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus64.out_valid) begin
      check("extra_result64", {63'b0, bus64.out_valid}, {63'b0, q64.size() > 0});
      if (q64.size() > 0) begin
        e = q64[0];
        check("data64", bus64.out_data, e.data);
        check("tag64", {59'b0, bus64.out_tag}, {59'b0, e.tag});
        check("nv64", {63'b0, bus64.out_nv}, {63'b0, e.nv});
        if (bus64.out_ready) void'(q64.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request was accepted.
  task automatic send32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] res, input logic nv);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send32_in_ready", {63'b0, bus.in_ready}, 64'd1);
    if (bus.in_ready) q32.push_back('{data: {32'b0, res}, tag: tag, nv: nv});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input logic [63:0] res, input logic nv);
    int waited = 0;
    bus64.in_valid = 1'b1;
    bus64.in_op    = op;
    bus64.in_a     = a;
    bus64.in_b     = b;
    bus64.in_tag   = tag;
    @(negedge clk);
    while (!bus64.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send64_in_ready", {63'b0, bus64.in_ready}, 64'd1);
    if (bus64.in_ready) q64.push_back('{data: res, tag: tag, nv: nv});
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
    check({name, "_q32_left"}, 64'(q32.size()), 64'd0);
    check({name, "_q64_left"}, 64'(q64.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int d0;
    bus.in_valid    = 1'b0;
    bus.in_op       = '0;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.in_op     = '0;
    bus64.in_a      = '0;
    bus64.in_b      = '0;
    bus64.in_tag    = '0;
    bus64.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst_out_data", {32'b0, bus.out_data}, 64'd0);
    check("rst_out_tag", {59'b0, bus.out_tag}, 64'd0);
    check("rst_out_nv", {63'b0, bus.out_nv}, 64'd0);
    check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("rst_out_valid64", {63'b0, bus64.out_valid}, 64'd0);

    // Back-to-back directed vectors, consumer always ready.
    @(posedge clk);
    #1;
    foreach (vecs[i]) send32(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].res, vecs[i].nv);
    drain("directed");

    // Eight tagged ops streamed with the consumer stalled for cycles 3..6.
    @(posedge clk);
    #1;
    idx = 0;
    d0  = done32;
    for (int c = 0; c < 60 && (idx < 8 || q32.size() != 0); c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      if (idx < 8) begin
        bus.in_valid = 1'b1;
        bus.in_op    = vecs[6+idx].op;
        bus.in_a     = vecs[6+idx].a;
        bus.in_b     = vecs[6+idx].b;
        bus.in_tag   = 5'(8 + idx);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check("stream_in_ready", {63'b0, bus.in_ready},
            {63'b0, !(q32.size() == 2 && !bus.out_ready)});
      if (idx < 8 && bus.in_ready) begin
        q32.push_back('{data: {32'b0, vecs[6+idx].res}, tag: 5'(8 + idx), nv: vecs[6+idx].nv});
        idx++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_all_sent", 64'(idx), 64'd8);
    check("stream_results", 64'(done32 - d0), 64'd8);
    drain("stream");

    // Reset with two operations in flight; they must never emerge.
    bus.out_ready = 1'b0;
    send32(FEQ, 32'h3F800000, 32'h3F800000, 5'd30, 32'h1, 1'b0);
    send32(FLT, 32'hBF800000, 32'h3F800000, 5'd31, 32'h1, 1'b0);
    rst_n = 1'b0;
    q32.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("midrst_out_data", {32'b0, bus.out_data}, 64'd0);
    check("midrst_out_tag", {59'b0, bus.out_tag}, 64'd0);
    check("midrst_out_nv", {63'b0, bus.out_nv}, 64'd0);
    check("midrst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    repeat (4) @(negedge clk);

    // Latency: presented after edge N, captured at N+1, valid after N+2.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_op    = FLE;
    bus.in_a     = 32'hBF800000;
    bus.in_b     = 32'h3F800000;
    bus.in_tag   = 5'd21;
    @(negedge clk);
    check("lat_in_ready", {63'b0, bus.in_ready}, 64'd1);
    q32.push_back('{data: 64'd1, tag: 5'd21, nv: 1'b0});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_early", {63'b0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check("lat_out_valid", {63'b0, bus.out_valid}, 64'd1);
    drain("latency");

    // Double precision instance.
    @(posedge clk);
    #1;
    send64(FLT,  64'hBFF0000000000000, 64'h3FF0000000000000, 5'd1, 64'd1, 1'b0);
    send64(FMAX, 64'h7FF8000000000000, 64'h7FF8000000000001, 5'd2, 64'h7FF8000000000000, 1'b0);
    send64(FEQ,  64'h0000000000000000, 64'h8000000000000000, 5'd3, 64'd1, 1'b0);
    send64(FMIN, 64'h7FF4000000000000, 64'h3FF0000000000000, 5'd4, 64'h3FF0000000000000, 1'b1);
    send64(FMIN, 64'h0000000000000000, 64'h8000000000000000, 5'd5, 64'h8000000000000000, 1'b0);
    drain("dp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
